mole_round_ctrl: RTL and testbench
==================================

MOLE_ROUND_CTRL -- requirements
Module: mole_round_ctrl

Interface
REQ-001 Parameter MOLE_TICKS, default 50_000_000, mole visible time in clk cycles (1 s at 50 MHz).
REQ-002 Parameter ROUNDS, default 20, moles per game.
REQ-003 Parameter LIVES, default 3, misses allowed before game over (1..3).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  level; already synchronised and debounced upstream.
REQ-007 sw  input  18  player slide switches, one per hole, already synchronised.
REQ-008 position  input  5  mole index from the random-position stage, valid 0..17.
REQ-009 trigger  output  1  one-cycle pulse requesting a new random position.
REQ-010 mole_leds  output  18  one-hot lit hole during ACTIVE, else zero.
REQ-011 score  output  8  hits this game, binary.
REQ-012 lives  output  2  remaining lives.
REQ-013 round_cnt  output  5  moles spawned this game.
REQ-014 game_over  output  1  high in OVER state.

Function
REQ-015 FSM states: IDLE, REQ, SETTLE, ACTIVE, RESULT, OVER.
REQ-016 IDLE: on start rising edge -> score=0, lives=LIVES, round_cnt=0, go to REQ.
REQ-017 REQ: trigger=1 for exactly one cycle, then SETTLE.
REQ-018 SETTLE: wait 3 cycles (upstream updates position 2 cycles after trigger), sample position on the 3rd cycle.
REQ-019 Sampled position >=18: discard, return to REQ (no round counted).
REQ-020 Valid sample: latch target, round_cnt+1, load timeout counter with MOLE_TICKS-1, go to ACTIVE.
REQ-021 ACTIVE: mole_leds = 1<<target; timeout counter decrements once per cycle.
REQ-022 Switch event = any bit of sw differing from its value one cycle earlier (toggle, either direction).
REQ-023 Hit: exactly one switch event, on bit target.
REQ-024 Miss: any event on a non-target bit, or more than one event in a cycle, or timeout counter reaching 0 with no hit.
REQ-025 Hit and timeout expiry in same cycle -> hit.
REQ-026 On hit or miss go to RESULT; mole_leds cleared in RESULT.
REQ-027 RESULT (1 cycle): hit -> score+1 saturating at 255; miss -> lives-1.
REQ-028 After RESULT: lives==0 or round_cnt==ROUNDS -> OVER, else REQ.
REQ-029 Switch events outside ACTIVE are ignored; edge register still tracks sw every cycle.
REQ-030 OVER: game_over=1, score/lives/round_cnt held; start rising edge -> restart as in REQ-016.
REQ-031 start held high is one edge only; start ignored outside IDLE and OVER.

Reset
REQ-032 On reset: state IDLE, trigger=0, mole_leds=0, score=0, lives=LIVES, round_cnt=0, game_over=0.
REQ-033 Switch history register loads 0 on reset; first cycle after reset may register events (ignored, not ACTIVE).
REQ-034 Reset mid-ACTIVE aborts round immediately; no score/lives update.

Structure
REQ-035 Shared package mole_pkg holds: state enum, NUM_HOLES=18, POS_W=5, SETTLE_CYCLES=3.
REQ-036 One sub-module sw_edge_detect (18-bit register + XOR, outputs event vector and event count>1 flag).
REQ-037 Timeout counter width = clog2(MOLE_TICKS).

Verification (bench uses MOLE_TICKS=20, ROUNDS=4, LIVES=2)
REQ-038 start pulse, position=5, toggle sw[5] 4 cycles into ACTIVE -> trigger one pulse, mole_leds=0x00020, score=1, lives=2.
REQ-039 position=7, no switch activity -> mole_leds cleared 20 cycles after ACTIVE entry, lives=1, score unchanged.
REQ-040 position=3, toggle sw[3] and sw[4] same cycle -> miss, lives decrements.
REQ-041 position=20 on sample -> second trigger pulse, round_cnt unchanged until valid position.
REQ-042 two misses -> game_over=1 with round_cnt=2; start -> score=0, lives=2, trigger pulses.
REQ-043 reset asserted during ACTIVE -> all outputs at reset values next edge; sw[target] toggle at timeout cycle -> counted as hit.

Source files
------------

// File: rtl/mole_round_ctrl_pkg.sv
// Shared types and constants for the whack-a-mole round controller.
package mole_pkg;

  localparam int NUM_HOLES     = 18;
  localparam int POS_W         = 5;
  localparam int SETTLE_CYCLES = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SETTLE,
    ST_ACTIVE,
    ST_RESULT,
    ST_OVER
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mole_round_ctrl_if.sv
// Player/position-stage inputs and game-status outputs of the round controller.
interface mole_round_ctrl_if;

  logic                           start;
  logic [mole_pkg::NUM_HOLES-1:0] sw;
  logic [mole_pkg::POS_W-1:0]     position;
  logic                           trigger;
  logic [mole_pkg::NUM_HOLES-1:0] mole_leds;
  logic [7:0]                     score;
  logic [1:0]                     lives;
  logic [4:0]                     round_cnt;
  logic                           game_over;

  modport master (
    output start, sw, position,
    input  trigger, mole_leds, score, lives, round_cnt, game_over
  );

  modport slave (
    input  start, sw, position,
    output trigger, mole_leds, score, lives, round_cnt, game_over
  );

endinterface

// File: rtl/mole_round_ctrl_sw_edge_detect.sv
// Flags every switch that toggled since the previous cycle, plus a flag for
// more than one toggle in the same cycle.
module sw_edge_detect
  import mole_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_HOLES-1:0] sw_i,
  output logic [NUM_HOLES-1:0] event_o,
  output logic                 multi_o
);

  logic [NUM_HOLES-1:0] hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_q <= '0;
    else       hist_q <= sw_i;
  end

  for (genvar gi = 0; gi < NUM_HOLES; gi++) begin : g_evt
    assign event_o[gi] = sw_i[gi] ^ hist_q[gi];
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_o = |(event_o & (event_o - NUM_HOLES'(1)));

endmodule

// File: rtl/mole_round_ctrl.sv
// Game sequencer: requests a random hole, lights it, judges the player's
// switch toggle as hit or miss, and keeps score, lives and round count.
module mole_round_ctrl
  import mole_pkg::*;
#(
  parameter int MOLE_TICKS = 50_000_000,
  parameter int ROUNDS     = 20,
  parameter int LIVES      = 3
) (
  input  logic             clk,
  input  logic             reset,
  mole_round_ctrl_if.slave bus
);

  localparam int TMR_W = (MOLE_TICKS > 1) ? $clog2(MOLE_TICKS) : 1;
  localparam logic [POS_W-1:0] HOLES_P = POS_W'(NUM_HOLES);

  state_t               state_q;
  logic                 start_q;
  logic [1:0]           settle_q;
  logic [TMR_W-1:0]     tmr_q;
  logic [POS_W-1:0]     target_q;
  logic                 hit_q;
  logic                 trigger_q;
  logic [NUM_HOLES-1:0] leds_q;
  logic [7:0]           score_q;
  logic [1:0]           lives_q;
  logic [4:0]           round_q;
  logic                 over_q;

  logic [NUM_HOLES-1:0] sw_event;
  logic                 sw_multi;
  logic                 start_rise_d;
  logic                 hit_d;
  logic                 miss_d;
  logic [1:0]           lives_d;

  sw_edge_detect u_edge (
    .clk     (clk),
    .reset   (reset),
    .sw_i    (bus.sw),
    .event_o (sw_event),
    .multi_o (sw_multi)
  );

  always_comb begin
    start_rise_d = bus.start & ~start_q;
    hit_d        = ~sw_multi & sw_event[target_q];
    miss_d       = (|sw_event) | (tmr_q == '0);
    lives_d      = hit_q ? lives_q : lives_q - 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      settle_q  <= '0;
      tmr_q     <= '0;
      target_q  <= '0;
      hit_q     <= 1'b0;
      trigger_q <= 1'b0;
      leds_q    <= '0;
      score_q   <= '0;
      lives_q   <= 2'(LIVES);
      round_q   <= '0;
      over_q    <= 1'b0;
    end else begin
      start_q <= bus.start;
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start_rise_d) begin
            score_q   <= '0;
            lives_q   <= 2'(LIVES);
            round_q   <= '0;
            over_q    <= 1'b0;
            trigger_q <= 1'b1;
            state_q   <= ST_REQ;
          end
        end
        ST_REQ: begin
          trigger_q <= 1'b0;
          settle_q  <= '0;
          state_q   <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_q == 2'(SETTLE_CYCLES - 1)) begin
            if (bus.position < HOLES_P) begin
              target_q <= bus.position;
              round_q  <= round_q + 5'd1;
              tmr_q    <= TMR_W'(MOLE_TICKS - 1);
              leds_q   <= NUM_HOLES'(1) << bus.position;
              state_q  <= ST_ACTIVE;
            end else begin
              // Out-of-range position: ask again without counting a round.
              trigger_q <= 1'b1;
              state_q   <= ST_REQ;
            end
          end else begin
            settle_q <= settle_q + 2'd1;
          end
        end
        ST_ACTIVE: begin
          // Hit is tested first so a hit on the expiry cycle still scores.
          if (hit_d || miss_d) begin
            hit_q   <= hit_d;
            leds_q  <= '0;
            state_q <= ST_RESULT;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        ST_RESULT: begin
          if (hit_q) score_q <= sat_inc8(score_q);
          lives_q <= lives_d;
          if (lives_d == 2'd0 || round_q == 5'(ROUNDS)) begin
            over_q  <= 1'b1;
            state_q <= ST_OVER;
          end else begin
            trigger_q <= 1'b1;
            state_q   <= ST_REQ;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.trigger   = trigger_q;
  assign bus.mole_leds = leds_q;
  assign bus.score     = score_q;
  assign bus.lives     = lives_q;
  assign bus.round_cnt = round_q;
  assign bus.game_over = over_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed game scenarios against a round-level timeline model of the controller.
module tb_mole_round_ctrl;
  import mole_pkg::*;

  localparam int TICKS = 20;
  localparam int NR    = 4;
  localparam int NL    = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mole_round_ctrl_if bif ();

  mole_round_ctrl #(
    .MOLE_TICKS (TICKS),
    .ROUNDS     (NR),
    .LIVES      (NL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  int errors = 0;
  int checks = 0;

  // Expected outputs, advanced by the stimulus along the game timeline.
  logic        exp_trig;
  logic [17:0] exp_leds;
  int          exp_score;
  int          exp_lives;
  int          exp_round;
  logic        exp_over;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("trigger",   bif.trigger,   exp_trig);
      check("mole_leds", bif.mole_leds, exp_leds);
      check("score",     bif.score,     exp_score);
      check("lives",     bif.lives,     exp_lives);
      check("round_cnt", bif.round_cnt, exp_round);
      check("game_over", bif.game_over, exp_over);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reset_exp();
    exp_trig  = 1'b0;
    exp_leds  = '0;
    exp_score = 0;
    exp_lives = NL;
    exp_round = 0;
    exp_over  = 1'b0;
  endtask

  // Raise start; the new game's trigger is visible one edge later.
  task automatic begin_game();
    bif.start = 1'b1;
    tick();
    exp_score = 0;
    exp_lives = NL;
    exp_round = 0;
    exp_over  = 1'b0;
    exp_trig  = 1'b1;
  endtask

  // Entered just after the edge that shows trigger. bad_pos>=0 is served
  // first and must be discarded; k<0 means no toggle (timeout); settle_bit>=0
  // toggles that switch while the position settles.
  task automatic play_round(input int bad_pos, input int pos, input int k,
                            input logic [17:0] tmask, input int settle_bit);
    bit hit;
    if (bad_pos >= 0) begin
      bif.position = 5'(bad_pos);
      tick(); exp_trig = 1'b0;
      tick(); tick(); tick(); exp_trig = 1'b1;
      check("retry_trigger", bif.trigger, 1);
    end
    bif.position = 5'(pos);
    tick(); exp_trig = 1'b0;
    if (settle_bit >= 0) bif.sw[settle_bit] = ~bif.sw[settle_bit];
    tick(); tick(); tick();
    exp_leds = 18'(1) << pos;
    exp_round++;
    if (k >= 0) begin
      repeat (k) tick();
      bif.sw = bif.sw ^ tmask;
      tick();
    end else begin
      repeat (TICKS) tick();
    end
    exp_leds = '0;
    hit = (k >= 0) && ($countones(tmask) == 1) && (tmask[pos] == 1'b1);
    tick();
    if (hit) exp_score = (exp_score == 255) ? 255 : exp_score + 1;
    else     exp_lives--;
    if (exp_lives == 0 || exp_round == NR) exp_over = 1'b1;
    else                                   exp_trig = 1'b1;
    $display("round %0d pos=%0d %s score=%0d lives=%0d over=%0d",
             exp_round, pos, hit ? "hit" : "miss", bif.score, bif.lives, bif.game_over);
  endtask

  initial begin
    reset        = 1'b1;
    bif.start    = 1'b0;
    bif.sw       = '0;
    bif.position = '0;
    set_reset_exp();
    chk_en = 1'b1;
    repeat (3) tick();
    check("rst_lives",   bif.lives,     2);
    check("rst_trigger", bif.trigger,   0);
    check("rst_over",    bif.game_over, 0);
    reset = 1'b0;
    tick();

    // Game 1: start stays high the whole game and must count as one edge.
    begin_game();
    play_round(-1, 5, 4, 18'h00020, -1);
    check("g1r1_score", bif.score, 1);
    check("g1r1_lives", bif.lives, 2);
    play_round(-1, 7, -1, 18'h0, 7);
    check("g1r2_lives", bif.lives, 1);
    check("g1r2_score", bif.score, 1);
    play_round(20, 3, 2, 18'h00018, -1);
    check("g1_over",  bif.game_over, 1);
    check("g1_round", bif.round_cnt, 3);
    repeat (3) tick();
    check("g1_held_over", bif.game_over, 1);

    // Game 2: restart from OVER, two misses end it.
    bif.start = 1'b0;
    tick();
    begin_game();
    check("g2_score", bif.score, 0);
    check("g2_lives", bif.lives, 2);
    check("g2_trig",  bif.trigger, 1);
    play_round(-1, 7, -1, 18'h0, -1);
    play_round(-1, 3, 5, 18'h00018, -1);
    check("g2_over",  bif.game_over, 1);
    check("g2_round", bif.round_cnt, 2);

    // Game 3: reset while the mole is lit aborts the round.
    bif.start = 1'b0;
    tick();
    begin_game();
    bif.start    = 1'b0;
    bif.position = 5'd9;
    tick(); exp_trig = 1'b0;
    tick(); tick(); tick();
    exp_leds  = 18'(1) << 9;
    exp_round = 1;
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    set_reset_exp();
    tick();
    check("rst_mid_leds",  bif.mole_leds, 0);
    check("rst_mid_round", bif.round_cnt, 0);
    check("rst_mid_lives", bif.lives,     2);
    reset = 1'b0;
    tick();

    // Game 4: hit on the expiry cycle, wrong-hole miss, then play to ROUNDS.
    begin_game();
    play_round(-1, 11, 19, 18'h00800, -1);
    check("g4_edge_hit", bif.score, 1);
    play_round(-1, 2, 0, 18'h00001, -1);
    play_round(-1, 17, 10, 18'h20000, -1);
    play_round(-1, 0, 1, 18'h00001, -1);
    check("g4_score", bif.score,     3);
    check("g4_lives", bif.lives,     1);
    check("g4_round", bif.round_cnt, 4);
    check("g4_over",  bif.game_over, 1);
    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
